// File: rtl/axis_upsizer_if.sv
// Purpose : bundles the narrow upstream and wide downstream AXI-Stream signals of one
//           axis_upsizer instance. Modport slave is the upsizer's own view; modport
//           master is the surrounding logic that feeds the narrow side and drains the wide one.
// Ports   : s_axis_* narrow input stream (tdata/tvalid/tlast in, tready out of the upsizer),
//           m_axis_* wide output stream (tdata/tkeep/tvalid/tfirst/tlast out, tready in).
interface axis_upsizer_if #(
  parameter int IN_BYTES = 1,
  parameter int RATIO    = 4
);
  localparam int OUT_BYTES = IN_BYTES * RATIO;

  logic [8*IN_BYTES-1:0]  s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tlast;
  logic                   s_axis_tready;

  logic [8*OUT_BYTES-1:0] m_axis_tdata;
  logic [OUT_BYTES-1:0]   m_axis_tkeep;
  logic                   m_axis_tvalid;
  logic                   m_axis_tfirst;
  logic                   m_axis_tlast;
  logic                   m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
           m_axis_tfirst, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
           m_axis_tfirst, m_axis_tlast
  );
endinterface

// File: rtl/axis_upsizer.sv
// Purpose : packs RATIO narrow beats of IN_BYTES bytes into one wide word, with per-byte
//           tkeep for short tails, tfirst/tlast markers and a completed-packet counter.
// Latency : 1 cycle from the completing input handshake to m_axis_tvalid; 1 word/cycle peak.
// Backpr. : s_axis_tready drops combinationally while the output word is held (valid & ~ready).
// Ports   : clk, reset_n (async, active-low), bus (axis_upsizer_if.slave: narrow in, wide out),
//           pkt_count (32-bit count of output tlast handshakes, wraps).
module axis_upsizer #(
  parameter int IN_BYTES   = 1,
  parameter int RATIO      = 4,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  axis_upsizer_if.slave       bus,
  output logic [31:0]         pkt_count
);

  localparam int SEG_W     = 8 * IN_BYTES;
  localparam int OUT_BYTES = IN_BYTES * RATIO;
  localparam int OUT_W     = 8 * OUT_BYTES;
  localparam int SLOT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

  // Position of the k-th beat of a word within the output word.
  function automatic int seg_of(input int k);
    return BIG_ENDIAN ? (RATIO - 1 - k) : k;
  endfunction

  logic [SLOT_W-1:0]    slot_q,    slot_d;
  logic [OUT_W-1:0]     acc_q,     acc_d;
  logic                 first_q,   first_d;
  logic [OUT_W-1:0]     m_dat_q,   m_dat_d;
  logic [OUT_BYTES-1:0] m_keep_q,  m_keep_d;
  logic                 m_vld_q,   m_vld_d;
  logic                 m_last_q,  m_last_d;
  logic                 m_first_q, m_first_d;
  logic [31:0]          pkt_cnt_q, pkt_cnt_d;

  logic                 s_rdy;
  logic                 s_acc;
  logic                 word_done;
  logic [OUT_W-1:0]     merged;
  logic [OUT_BYTES-1:0] fill_keep;

  always_comb begin
    // Input is stalled only while a held word cannot leave this cycle, and during reset.
    s_rdy     = reset_n & ~(m_vld_q & ~bus.m_axis_tready);
    s_acc     = bus.s_axis_tvalid & s_rdy;
    word_done = s_acc & ((slot_q == SLOT_W'(RATIO - 1)) | bus.s_axis_tlast);

    // Accumulator with the current beat dropped into its lane. Lanes beyond the current
    // slot are still zero because the accumulator is cleared whenever a word completes.
    merged    = acc_q;
    fill_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (SLOT_W'(k) == slot_q)
        merged[seg_of(k)*SEG_W +: SEG_W] = bus.s_axis_tdata;
      if (SLOT_W'(k) <= slot_q)
        fill_keep[seg_of(k)*IN_BYTES +: IN_BYTES] = '1;
    end

    slot_d    = slot_q;
    acc_d     = acc_q;
    first_d   = first_q;
    m_dat_d   = m_dat_q;
    m_keep_d  = m_keep_q;
    m_vld_d   = m_vld_q;
    m_last_d  = m_last_q;
    m_first_d = m_first_q;
    pkt_cnt_d = pkt_cnt_q;

    if (s_acc) begin
      if (word_done) begin
        slot_d = '0;
        acc_d  = '0;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
        acc_d  = merged;
      end
    end

    // A completing beat is only accepted when the output slot is empty or draining,
    // so loading here never overwrites an un-consumed word.
    if (word_done) begin
      m_vld_d   = 1'b1;
      m_dat_d   = merged;
      m_keep_d  = fill_keep;
      m_last_d  = bus.s_axis_tlast;
      m_first_d = first_q;
      first_d   = bus.s_axis_tlast;
    end else if (bus.m_axis_tready) begin
      m_vld_d   = 1'b0;
    end

    if (m_vld_q & bus.m_axis_tready & m_last_q)
      pkt_cnt_d = pkt_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q    <= '0;
      acc_q     <= '0;
      first_q   <= 1'b1;
      m_dat_q   <= '0;
      m_keep_q  <= '0;
      m_vld_q   <= 1'b0;
      m_last_q  <= 1'b0;
      m_first_q <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      slot_q    <= slot_d;
      acc_q     <= acc_d;
      first_q   <= first_d;
      m_dat_q   <= m_dat_d;
      m_keep_q  <= m_keep_d;
      m_vld_q   <= m_vld_d;
      m_last_q  <= m_last_d;
      m_first_q <= m_first_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign bus.s_axis_tready = s_rdy;
  assign bus.m_axis_tdata  = m_dat_q;
  assign bus.m_axis_tkeep  = m_keep_q;
  assign bus.m_axis_tvalid = m_vld_q;
  assign bus.m_axis_tfirst = m_first_q;
  assign bus.m_axis_tlast  = m_last_q;
  assign pkt_count         = pkt_cnt_q;

endmodule
